// File: rtl/fsm_state_checker.sv
// rtl/fsm_state_checker.sv - passive golden-model checker for the 13-state LED sequencer
module fsm_state_checker #(
  parameter int STEP_W = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic [3:0]        state_in,
  input  logic [1:0]        inp,
  input  logic              clr,
  output logic              err,
  output logic              mismatch,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_count,
  output logic [STEP_W-1:0] step_count,
  output logic [3:0]        exp_state,
  output logic [3:0]        bad_state,
  output logic [12:0]       visited
);

  // 15 is a poison prediction: it can never equal a legal state, and an
  // illegal state at the compare is flagged separately anyway.
  function automatic logic [3:0] golden_next(input logic [3:0] s, input logic [1:0] i);
    logic [3:0] n;
    case (s)
      4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd9: n = s + 4'd1;
      4'd3:                               n = (i == 2'd0) ? 4'd4 : ((i == 2'd1) ? 4'd5 : 4'd6);
      4'd4, 4'd5, 4'd6:                   n = 4'd7;
      4'd10:                              n = (i == 2'd0) ? 4'd11 : 4'd12;
      4'd11, 4'd12:                       n = 4'd0;
      default:                            n = 4'd15;
    endcase
    return n;
  endfunction

  logic              pending_q, pending_d;
  logic              first_q, first_d;
  logic              err_q, err_d;
  logic              mismatch_q, mismatch_d;
  logic              illegal_q, illegal_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [STEP_W-1:0] step_count_q, step_count_d;
  logic [3:0]        exp_state_q, exp_state_d;
  logic [3:0]        bad_state_q, bad_state_d;
  logic [12:0]       visited_q, visited_d;
  logic              cmp_illegal, cmp_err;

  always_comb begin
    pending_d    = pending_q;
    first_d      = first_q;
    err_d        = err_q;
    err_count_d  = err_count_q;
    step_count_d = step_count_q;
    exp_state_d  = exp_state_q;
    bad_state_d  = bad_state_q;
    visited_d    = visited_q;

    cmp_illegal  = pending_q && (state_in > 4'd12);
    cmp_err      = pending_q && ((state_in > 4'd12) || (state_in != exp_state_q));
    mismatch_d   = cmp_err;
    illegal_d    = cmp_illegal;

    if (step) begin
      exp_state_d  = golden_next(state_in, inp);
      pending_d    = 1'b1;
      step_count_d = step_count_q + STEP_W'(1);
    end else if (pending_q) begin
      pending_d = 1'b0;
    end

    if (clr) begin
      err_d       = 1'b0;
      err_count_d = '0;
      visited_d   = '0;
      bad_state_d = '0;
    end

    // The first step after reset/clr also covers its source state (e.g. state 0).
    if (clr) begin
      first_d = 1'b1;
    end else if (step) begin
      first_d = 1'b0;
    end
    if (step && first_q && (state_in <= 4'd12)) begin
      visited_d[state_in] = 1'b1;
    end

    if (pending_q && (state_in <= 4'd12)) begin
      visited_d[state_in] = 1'b1;
    end

    if (cmp_err) begin
      err_d       = 1'b1;
      bad_state_d = state_in;
      if (err_count_d != {ERR_W{1'b1}}) begin
        err_count_d = err_count_d + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      first_q      <= 1'b1;
      err_q        <= 1'b0;
      mismatch_q   <= 1'b0;
      illegal_q    <= 1'b0;
      err_count_q  <= '0;
      step_count_q <= '0;
      exp_state_q  <= '0;
      bad_state_q  <= '0;
      visited_q    <= '0;
    end else begin
      pending_q    <= pending_d;
      first_q      <= first_d;
      err_q        <= err_d;
      mismatch_q   <= mismatch_d;
      illegal_q    <= illegal_d;
      err_count_q  <= err_count_d;
      step_count_q <= step_count_d;
      exp_state_q  <= exp_state_d;
      bad_state_q  <= bad_state_d;
      visited_q    <= visited_d;
    end
  end

  assign err        = err_q;
  assign mismatch   = mismatch_q;
  assign illegal    = illegal_q;
  assign err_count  = err_count_q;
  assign step_count = step_count_q;
  assign exp_state  = exp_state_q;
  assign bad_state  = bad_state_q;
  assign visited    = visited_q;

endmodule

// File: tb/tb_fsm_state_checker.sv
// tb/tb_fsm_state_checker.sv - scoreboard bench for fsm_state_checker
module tb_fsm_state_checker;
  localparam int STEP_W = 16;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              rst, step, clr;
  logic [3:0]        state_in;
  logic [1:0]        inp;
  logic              err, mismatch, illegal;
  logic [ERR_W-1:0]  err_count;
  logic [STEP_W-1:0] step_count;
  logic [3:0]        exp_state, bad_state;
  logic [12:0]       visited;

  fsm_state_checker #(.STEP_W(STEP_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .step(step), .state_in(state_in), .inp(inp), .clr(clr),
    .err(err), .mismatch(mismatch), .illegal(illegal), .err_count(err_count),
    .step_count(step_count), .exp_state(exp_state), .bad_state(bad_state), .visited(visited)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   due;
    logic mis;
    logic ill;
  } pulse_t;
  pulse_t sb[$];
  pulse_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic              m_err;
  int                m_errc;
  logic [STEP_W-1:0] m_steps;
  logic [3:0]        m_exp, m_bad;
  logic [12:0]       m_vis;
  logic              m_first;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic [1:0] i);
    if (s <= 4'd2 || (s >= 4'd7 && s <= 4'd9)) return s + 4'd1;
    if (s == 4'd3) return (i == 2'd0) ? 4'd4 : ((i == 2'd1) ? 4'd5 : 4'd6);
    if (s <= 4'd6) return 4'd7;
    if (s == 4'd10) return (i == 2'd0) ? 4'd11 : 4'd12;
    if (s <= 4'd12) return 4'd0;
    return 4'd15;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_err = 0; m_errc = 0; m_steps = '0; m_exp = '0; m_bad = '0; m_vis = '0; m_first = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] src, input logic [1:0] iv);
    if (m_first && src <= 4'd12) m_vis[src] = 1'b1;
    m_first = 1'b0;
    m_steps = m_steps + 1'b1;
    m_exp   = ref_next(src, iv);
  endtask

  // Called in the compare cycle, before any model_step of the same cycle.
  task automatic model_compare(input logic [3:0] nxt, input logic with_clr);
    logic mis, ill;
    ill = (nxt > 4'd12);
    mis = ill || (nxt != m_exp);
    if (with_clr) begin
      m_err = 0; m_errc = 0; m_vis = '0; m_bad = '0; m_first = 1'b1;
    end
    if (nxt <= 4'd12) m_vis[nxt] = 1'b1;
    if (mis) begin
      m_err = 1'b1;
      m_bad = nxt;
      if (m_errc < 255) m_errc++;
    end
    sb.push_back('{cyc + 1, mis, ill});
  endtask

  task automatic do_step(input logic [3:0] src, input logic [1:0] iv, input logic [3:0] nxt,
                         input logic with_clr);
    state_in = src; inp = iv; step = 1'b1;
    model_step(src, iv);
    tick;
    step = 1'b0; state_in = nxt; clr = with_clr;
    model_compare(nxt, with_clr);
    tick;
    clr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_err"},        err,        m_err);
    check_eq({tag, "_err_count"},  err_count,  m_errc);
    check_eq({tag, "_step_count"}, step_count, m_steps);
    check_eq({tag, "_exp_state"},  exp_state,  m_exp);
    check_eq({tag, "_bad_state"},  bad_state,  m_bad);
    check_eq({tag, "_visited"},    visited,    m_vis);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check_eq("pulse_mismatch", mismatch, mon_e.mis);
        check_eq("pulse_illegal",  illegal,  mon_e.ill);
      end else begin
        check_eq("idle_mismatch", mismatch, 1'b0);
        check_eq("idle_illegal",  illegal,  1'b0);
      end
    end
  end

  initial begin
    logic [3:0] cur, nxt;
    logic [1:0] iv;
    logic [STEP_W-1:0] saved_steps;
    logic [3:0] seq [4];

    rst = 1'b1; step = 1'b0; clr = 1'b0; state_in = '0; inp = '0;
    model_reset();
    repeat (2) tick;
    check_outputs("reset");
    check_eq("reset_mismatch", mismatch, 1'b0);
    check_eq("reset_illegal",  illegal,  1'b0);
    rst = 1'b0;
    tick;

    // legal walk, one step every 4 cycles
    cur = 4'd0;
    for (int k = 0; k < 11; k++) begin
      iv  = (cur == 4'd3) ? 2'd1 : 2'd0;
      nxt = ref_next(cur, iv);
      do_step(cur, iv, nxt, 1'b0);
      repeat (2) tick;
      cur = nxt;
    end
    check_outputs("walk");
    check_eq("walk_steps_11", step_count, 11);
    check_eq("walk_visited_set", visited, 13'b0_1111_1010_1111);

    // wrong branch taken at the dispatch state
    do_step(4'd3, 2'd2, 4'd5, 1'b0);
    tick;
    check_outputs("mis");
    check_eq("mis_exp6", exp_state, 4'd6);
    check_eq("mis_bad5", bad_state, 4'd5);

    // illegal successor
    do_step(4'd10, 2'd3, 4'd14, 1'b0);
    tick;
    check_outputs("ill");
    check_eq("ill_errc2", err_count, 2);

    // saturation of the error counter
    for (int k = 0; k < 300; k++) do_step(4'd0, 2'd0, 4'd5, 1'b0);
    tick;
    check_outputs("sat");
    check_eq("sat_255", err_count, 255);

    saved_steps = m_steps;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    m_err = 0; m_errc = 0; m_vis = '0; m_bad = '0; m_first = 1'b1;
    check_outputs("clr");
    check_eq("clr_steps_kept", step_count, saved_steps);

    // clr coinciding with an error: the error wins
    do_step(4'd3, 2'd0, 4'd9, 1'b1);
    tick;
    check_outputs("clr_err");
    check_eq("clr_err_vis", visited, 13'h200);

    // back-to-back steps: 0,1,2 stepped on consecutive cycles, then 3 compared
    seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd2; seq[3] = 4'd3;
    for (int k = 0; k < 4; k++) begin
      state_in = seq[k]; inp = 2'd0; step = (k < 3);
      if (k > 0) model_compare(seq[k], 1'b0);
      if (k < 3) model_step(seq[k], 2'd0);
      tick;
      check_eq("b2b_steps", step_count, m_steps);
    end
    step = 1'b0;
    repeat (2) tick;
    check_outputs("b2b");

    // async reset while a wrong state is pending
    state_in = 4'd0; inp = 2'd0; step = 1'b1;
    tick;
    step = 1'b0; state_in = 4'd7;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    check_eq("arst_mismatch", mismatch, 1'b0);
    check_eq("arst_illegal",  illegal,  1'b0);
    tick;
    rst = 1'b0;
    repeat (3) tick;
    check_outputs("arst_after");

    do_step(4'd0, 2'd0, 4'd1, 1'b0);
    repeat (3) tick;
    check_outputs("recover");
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
